// File: rtl/alsu.sv
// alsu: registered 3-bit arithmetic/logic/shift unit with a 6-bit result.
// Stage 1 registers every operand and control input; stage 2 produces out
// and the invalid-operation LED bank from those registers.
// Optional feature macro: ALSU_INVALID_LEDS_EN (blinking LED bank on invalid ops).
module alsu #(
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  A,
  input  logic [2:0]  B,
  input  logic        cin,
  input  logic        serial_in,
  input  logic        red_op_A,
  input  logic        red_op_B,
  input  logic [2:0]  opcode,
  input  logic        bypass_A,
  input  logic        bypass_B,
  input  logic        direction,
  output logic [15:0] leds,
  output logic [5:0]  out
);

  localparam bit PRI_A   = (INPUT_PRIORITY == "A");
  localparam bit ADD_CIN = (FULL_ADDER == "ON");

  logic [2:0] a_r, b_r, opcode_r;
  logic       cin_r, serial_r, red_a_r, red_b_r, bypass_a_r, bypass_b_r, dir_r;

  logic       invalid;
  logic [2:0] bypass_opnd, red_opnd;
  logic [5:0] out_nxt;

  // stage 1: capture all inputs every cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_r        <= '0;
      b_r        <= '0;
      opcode_r   <= '0;
      cin_r      <= 1'b0;
      serial_r   <= 1'b0;
      red_a_r    <= 1'b0;
      red_b_r    <= 1'b0;
      bypass_a_r <= 1'b0;
      bypass_b_r <= 1'b0;
      dir_r      <= 1'b0;
    end else begin
      a_r        <= A;
      b_r        <= B;
      opcode_r   <= opcode;
      cin_r      <= cin;
      serial_r   <= serial_in;
      red_a_r    <= red_op_A;
      red_b_r    <= red_op_B;
      bypass_a_r <= bypass_A;
      bypass_b_r <= bypass_B;
      dir_r      <= direction;
    end
  end

  // stage 2 next value: invalid beats bypass beats opcode
  always_comb begin
    out_nxt     = '0;
    invalid     = (opcode_r[2] && opcode_r[1]) ||
                  ((red_a_r || red_b_r) && (opcode_r > 3'd1));
    bypass_opnd = (bypass_a_r && (!bypass_b_r || PRI_A)) ? a_r : b_r;
    red_opnd    = (red_a_r && (!red_b_r || PRI_A)) ? a_r : b_r;
    if (invalid) begin
      out_nxt = '0;
    end else if (bypass_a_r || bypass_b_r) begin
      out_nxt = {3'b000, bypass_opnd};
    end else begin
      case (opcode_r)
        3'd0: begin
          if (red_a_r || red_b_r) out_nxt = {5'b0, &red_opnd};
          else                    out_nxt = {3'b000, a_r & b_r};
        end
        3'd1: begin
          if (red_a_r || red_b_r) out_nxt = {5'b0, ^red_opnd};
          else                    out_nxt = {3'b000, a_r ^ b_r};
        end
        3'd2: out_nxt = {3'b000, a_r} + {3'b000, b_r} + {5'b0, cin_r & ADD_CIN};
        3'd3: out_nxt = {3'b000, a_r} * {3'b000, b_r};
        3'd4: out_nxt = dir_r ? {out[4:0], serial_r} : {serial_r, out[5:1]};
        3'd5: out_nxt = dir_r ? {out[4:0], out[5]} : {out[0], out[5:1]};
        default: out_nxt = '0;
      endcase
    end
  end

  // stage 2: result register
  always_ff @(posedge clk) begin
    if (!rst) out <= '0;
    else      out <= out_nxt;
  end

`ifdef ALSU_INVALID_LEDS_EN
  logic [15:0] leds_r;

  // LED bank toggles all-on/all-off while the registered op is invalid
  always_ff @(posedge clk) begin
    if (!rst)         leds_r <= '0;
    else if (invalid) leds_r <= ~leds_r;
    else              leds_r <= '0;
  end

  assign leds = leds_r;
`else
  assign leds = 16'h0000;
`endif

endmodule

// File: tb/tb_alsu.sv
// tb_alsu: directed plus randomized stimulus against a cycle-level
// behavioural model of the ALSU (default parameters: priority A, full adder on).
module tb_alsu;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] op;
    logic       ra;
    logic       rb;
    logic       ba;
    logic       bb;
    logic       c;
    logic       sn;
    logic       d;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  A, B, opcode;
  logic        cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction;
  logic [15:0] leds;
  logic [5:0]  out;

  int n_checks = 0;
  int n_fail   = 0;

  stim_t       s1_m;
  int          out_m;
  logic [15:0] leds_m;

  alsu dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .serial_in (serial_in),
    .red_op_A  (red_op_A),
    .red_op_B  (red_op_B),
    .opcode    (opcode),
    .bypass_A  (bypass_A),
    .bypass_B  (bypass_B),
    .direction (direction),
    .leds      (leds),
    .out       (out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic stim_t mk(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op,
                               input logic ra, input logic rb, input logic ba, input logic bb,
                               input logic c, input logic sn, input logic d);
    stim_t s;
    s.a = a; s.b = b; s.op = op; s.ra = ra; s.rb = rb; s.ba = ba; s.bb = bb;
    s.c = c; s.sn = sn; s.d = d;
    return s;
  endfunction

  function automatic bit is_invalid(input stim_t s);
    return (s.op >= 6) || ((s.ra || s.rb) && s.op >= 2);
  endfunction

  // result the unit should produce from registered inputs s and current result cur
  function automatic int next_out(input stim_t s, input int cur);
    int av = int'(s.a);
    int bv = int'(s.b);
    int opnd;
    if (is_invalid(s)) return 0;
    if (s.ba && s.bb) return av;
    if (s.ba) return av;
    if (s.bb) return bv;
    opnd = s.ra ? av : bv;
    case (int'(s.op))
      0: return (s.ra || s.rb) ? ((opnd == 7) ? 1 : 0) : (av & bv);
      1: return (s.ra || s.rb) ? ($countones(opnd[2:0]) % 2) : (av ^ bv);
      2: return av + bv + int'(s.c);
      3: return av * bv;
      4: return s.d ? (cur * 2 + int'(s.sn)) % 64 : int'(s.sn) * 32 + cur / 2;
      5: return s.d ? (cur * 2) % 64 + cur / 32 : (cur % 2) * 32 + cur / 2;
      default: return 0;
    endcase
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s = stim_t'($urandom);
    s.op = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 5)) : 3'($urandom_range(0, 7));
    s.ra = ($urandom_range(0, 3) == 0);
    s.rb = ($urandom_range(0, 3) == 0);
    s.ba = ($urandom_range(0, 7) == 0);
    s.bb = ($urandom_range(0, 7) == 0);
    return s;
  endfunction

  // apply s for one cycle (inputs set away from the edge), advance model, compare
  task automatic step(input stim_t s, input logic rst_v);
    rst = rst_v;
    A = s.a; B = s.b; opcode = s.op; red_op_A = s.ra; red_op_B = s.rb;
    bypass_A = s.ba; bypass_B = s.bb; cin = s.c; serial_in = s.sn; direction = s.d;
    @(posedge clk);
    if (!rst_v) begin
      out_m  = 0;
      leds_m = '0;
      s1_m   = '0;
    end else begin
`ifdef ALSU_INVALID_LEDS_EN
      leds_m = is_invalid(s1_m) ? ~leds_m : 16'h0000;
`else
      leds_m = 16'h0000;
`endif
      out_m = next_out(s1_m, out_m);
      s1_m  = s;
    end
    @(negedge clk);
    check_val("out_model", {10'b0, out}, 16'(out_m));
    check_val("leds_model", leds, leds_m);
  endtask

  initial begin
    stim_t s;
    s1_m = '0; out_m = 0; leds_m = '0;

    step(rand_stim(), 1'b0);
    check_val("reset_out", {10'b0, out}, 16'h0000);
    check_val("reset_leds", leds, 16'h0000);

    s = mk(3'd5, 3'd2, 3'd3, 0, 0, 1, 1, 0, 0, 0);
    step(s, 1'b1); step(s, 1'b1);
    check_val("bypass_both", {10'b0, out}, 16'd5);

    s = mk(3'd7, 3'd3, 3'd0, 1, 0, 0, 0, 0, 0, 0);
    step(s, 1'b1); step(s, 1'b1);
    check_val("and_red_a", {10'b0, out}, 16'd1);
    s = mk(3'd7, 3'd3, 3'd0, 0, 0, 0, 0, 0, 0, 0);
    step(s, 1'b1); step(s, 1'b1);
    check_val("and_ab", {10'b0, out}, 16'd3);

    s = mk(3'd7, 3'd7, 3'd2, 0, 0, 0, 0, 1, 0, 0);
    step(s, 1'b1); step(s, 1'b1);
    check_val("add_cin", {10'b0, out}, 16'd15);
    s = mk(3'd6, 3'd7, 3'd3, 0, 0, 0, 0, 0, 0, 0);
    step(s, 1'b1); step(s, 1'b1);
    check_val("mul", {10'b0, out}, 16'd42);

    s = mk(3'd7, 3'd3, 3'd0, 1, 0, 0, 0, 0, 0, 0);
    step(s, 1'b1); step(s, 1'b1);
    step(mk(3'd0, 3'd0, 3'd4, 0, 0, 0, 0, 0, 1, 1), 1'b1);
    s = mk(3'd0, 3'd0, 3'd5, 0, 0, 0, 0, 0, 0, 0);
    step(s, 1'b1);
    check_val("shift_left", {10'b0, out}, 16'h0003);
    step(s, 1'b1);
    check_val("rotate_right", {10'b0, out}, 16'h0021);

    s = mk(3'd3, 3'd4, 3'd6, 0, 0, 1, 0, 0, 0, 0);
    step(s, 1'b1); step(s, 1'b1);
    check_val("inv_op6_out", {10'b0, out}, 16'h0000);
`ifdef ALSU_INVALID_LEDS_EN
    check_val("inv_leds_on", leds, 16'hFFFF);
    step(s, 1'b1);
    check_val("inv_leds_off", leds, 16'h0000);
`else
    check_val("inv_leds_tied", leds, 16'h0000);
`endif
    s = mk(3'd3, 3'd4, 3'd2, 0, 1, 0, 0, 1, 0, 0);
    step(s, 1'b1); step(s, 1'b1); step(s, 1'b1);
    check_val("inv_red_add_out", {10'b0, out}, 16'h0000);

    s = mk(3'd7, 3'd7, 3'd3, 0, 0, 0, 0, 0, 0, 0);
    step(s, 1'b1); step(s, 1'b1);
    s = mk(3'd0, 3'd0, 3'd4, 0, 0, 0, 0, 0, 1, 1);
    step(s, 1'b1); step(s, 1'b1);
    step(s, 1'b0);
    check_val("reset_mid_shift", {10'b0, out}, 16'h0000);

    for (int i = 0; i < 600; i++) begin
      step(rand_stim(), ($urandom_range(0, 49) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
